// File: rtl/bloom_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bloom_access_ctrl_pkg
//  Description : Shared definitions for the bloom-filter SRAM access
//                controller: FSM state encodings, slot-word field positions
//                and the default SRAM word width.
//  Revision    : 1.0  initial release
// ============================================================================
package bloom_access_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WR0      = 4'd1,
    S_WR1      = 4'd2,
    S_RD0      = 4'd3,
    S_RD0_WAIT = 4'd4,
    S_RD1      = 4'd5,
    S_RD1_WAIT = 4'd6,
    S_EVAL     = 4'd7,
    S_CLR0     = 4'd8,
    S_CLR1     = 4'd9,
    S_SWEEP    = 4'd10
  } state_t;

  // Slot word: [35] valid, [34:32] zero, [31:0] timestamp
  localparam int VALID_BIT           = 35;
  localparam int TS_MSB              = 31;
  localparam int DEF_SRAM_DATA_WIDTH = 36;

endpackage
`default_nettype wire

// File: rtl/bloom_access_ctrl_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : bloom_access_ctrl_sweeper
//  Description : Background aging for the bloom table. Counts cycles the
//                controller spends in IDLE; after SWEEP_PERIOD of them it
//                raises sweep_pending until the controller reports that the
//                zeroing write to sweep_addr completed, then advances the
//                address (wrapping over the whole SRAM).
//  Ports       : clk, reset         - clock, async active-high reset
//                in_idle            - controller is in IDLE this cycle
//                sweep_done         - sweep write acknowledged this cycle
//                sweep_pending      - registered pending flag
//                sweep_pending_next - next-state value of the pending flag
//                sweep_addr         - address of the next slot to clear
//  Revision    : 1.0  initial release
// ============================================================================
module bloom_access_ctrl_sweeper #(
  parameter int SRAM_ADDR_WIDTH = 19,
  parameter int SWEEP_PERIOD    = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_idle,
  input  logic                       sweep_done,
  output logic                       sweep_pending,
  output logic                       sweep_pending_next,
  output logic [SRAM_ADDR_WIDTH-1:0] sweep_addr
);

  localparam int CNT_W = $clog2(SWEEP_PERIOD + 1);

  logic [CNT_W-1:0]           idle_cnt_q, idle_cnt_d;
  logic                       pending_q, pending_d;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    pending_d  = pending_q;
    addr_d     = addr_q;
    if (sweep_done) begin
      pending_d = 1'b0;
      addr_d    = addr_q + SRAM_ADDR_WIDTH'(1);
    end else if (in_idle && !pending_q) begin
      // Counter is frozen while a sweep is owed so periods never stack up.
      if (idle_cnt_q == CNT_W'(SWEEP_PERIOD - 1)) begin
        idle_cnt_d = '0;
        pending_d  = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt_q <= '0;
      pending_q  <= 1'b0;
      addr_q     <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      pending_q  <= pending_d;
      addr_q     <= addr_d;
    end
  end

  assign sweep_pending      = pending_q;
  assign sweep_pending_next = pending_d;
  assign sweep_addr         = addr_q;

endmodule
`default_nettype wire

// File: rtl/bloom_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bloom_access_ctrl
//  Description : Sequences all accesses to the bloom-filter SRAM on behalf of
//                the TCP tuple parser. Inserts stamp both hashed slots with
//                the acceptance timestamp; lookups read both slots and, when
//                both are valid, report an RTT sample and clear the slots.
//  Ports       : clk, reset                 - clock, async active-high reset
//                bloom_wr/bloom_rdy         - request handshake
//                index_0/index_1/pkt_is_ack - request payload
//                sram_*                     - off-chip SRAM port (req/ack,
//                                             read data with rd_vld)
//                rtt_valid/rtt_value        - RTT sample strobe and value
//                num_inserts/matches/misses - statistics counters
//  Option      : define BLOOM_ACCESS_CTRL_SWEEP_EN to enable periodic aging
//                writes through bloom_access_ctrl_sweeper.
//  Revision    : 1.0  initial release
// ============================================================================
module bloom_access_ctrl
  import bloom_access_ctrl_pkg::*;
#(
  parameter int SRAM_ADDR_WIDTH = 19,
  parameter int HASH_BITS       = SRAM_ADDR_WIDTH,
  parameter int SRAM_DATA_WIDTH = DEF_SRAM_DATA_WIDTH,
  parameter int TS_WIDTH        = 32,
  parameter int SWEEP_PERIOD    = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       bloom_wr,
  output logic                       bloom_rdy,
  input  logic [HASH_BITS-1:0]       index_0,
  input  logic [HASH_BITS-1:0]       index_1,
  input  logic                       pkt_is_ack,
  output logic                       sram_req,
  output logic                       sram_rd_wr_L,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0] sram_wr_data,
  input  logic                       sram_ack,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_data,
  input  logic                       sram_rd_vld,
  output logic                       rtt_valid,
  output logic [TS_WIDTH-1:0]        rtt_value,
  output logic [31:0]                num_inserts,
  output logic [31:0]                num_matches,
  output logic [31:0]                num_misses
);

  state_t                     state_q, state_d;
  logic                       bloom_rdy_q, bloom_rdy_d;
  logic                       sram_req_q, sram_req_d;
  logic                       sram_rd_wr_l_q, sram_rd_wr_l_d;
  logic [SRAM_ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic [SRAM_DATA_WIDTH-1:0] sram_wr_data_q, sram_wr_data_d;
  logic [SRAM_ADDR_WIDTH-1:0] idx0_q, idx0_d, idx1_q, idx1_d;
  logic [TS_WIDTH-1:0]        ts_q, ts_d, ts_req_q, ts_req_d;
  logic                       w0_valid_q, w0_valid_d;
  logic [TS_WIDTH-1:0]        w0_ts_q, w0_ts_d;
  logic                       rtt_valid_q, rtt_valid_d;
  logic [TS_WIDTH-1:0]        rtt_value_q, rtt_value_d;
  logic [31:0]                num_inserts_q, num_inserts_d;
  logic [31:0]                num_matches_q, num_matches_d;
  logic [31:0]                num_misses_q, num_misses_d;

  logic                       sweep_pending, sweep_pending_next;
  logic [SRAM_ADDR_WIDTH-1:0] sweep_addr;

`ifdef BLOOM_ACCESS_CTRL_SWEEP_EN
  logic sweep_done;
  assign sweep_done = (state_q == S_SWEEP) && sram_ack;

  bloom_access_ctrl_sweeper #(
    .SRAM_ADDR_WIDTH (SRAM_ADDR_WIDTH),
    .SWEEP_PERIOD    (SWEEP_PERIOD)
  ) u_sweeper (
    .clk                (clk),
    .reset              (reset),
    .in_idle            (state_q == S_IDLE),
    .sweep_done         (sweep_done),
    .sweep_pending      (sweep_pending),
    .sweep_pending_next (sweep_pending_next),
    .sweep_addr         (sweep_addr)
  );
`else
  assign sweep_pending      = 1'b0;
  assign sweep_pending_next = 1'b0;
  assign sweep_addr         = '0;
  logic unused_sweep_cfg;
  assign unused_sweep_cfg = (SWEEP_PERIOD != 0);
`endif

  // Only the valid bit and timestamp of a read word carry information.
  logic unused_rd_bits;
  assign unused_rd_bits = ^sram_rd_data[VALID_BIT-1:TS_MSB+1];

  // Ages are taken against the lookup's own acceptance timestamp, so the RTT
  // is the packet-to-packet gap independent of SRAM wait states. Modular
  // subtraction keeps the result correct across a timestamp wrap.
  logic [TS_WIDTH-1:0] age0, age1;
  logic                hit;
  assign age0 = ts_req_q - w0_ts_q;
  assign age1 = ts_req_q - TS_WIDTH'(sram_rd_data[TS_MSB:0]);
  assign hit  = w0_valid_q && sram_rd_data[VALID_BIT];

  always_comb begin
    state_d        = state_q;
    sram_req_d     = sram_req_q;
    sram_rd_wr_l_d = sram_rd_wr_l_q;
    sram_addr_d    = sram_addr_q;
    sram_wr_data_d = sram_wr_data_q;
    idx0_d         = idx0_q;
    idx1_d         = idx1_q;
    ts_d           = ts_q + TS_WIDTH'(1);
    ts_req_d       = ts_req_q;
    w0_valid_d     = w0_valid_q;
    w0_ts_d        = w0_ts_q;
    rtt_valid_d    = 1'b0;
    rtt_value_d    = rtt_value_q;
    num_inserts_d  = num_inserts_q;
    num_matches_d  = num_matches_q;
    num_misses_d   = num_misses_q;

    case (state_q)
      S_IDLE: begin
        if (bloom_wr && bloom_rdy_q) begin
          idx0_d      = SRAM_ADDR_WIDTH'(index_0);
          idx1_d      = SRAM_ADDR_WIDTH'(index_1);
          ts_req_d    = ts_q;
          sram_req_d  = 1'b1;
          sram_addr_d = SRAM_ADDR_WIDTH'(index_0);
          if (pkt_is_ack) begin
            state_d        = S_RD0;
            sram_rd_wr_l_d = 1'b1;
          end else begin
            state_d        = S_WR0;
            sram_rd_wr_l_d = 1'b0;
            sram_wr_data_d = {1'b1, {(SRAM_DATA_WIDTH-TS_WIDTH-1){1'b0}}, ts_q};
            num_inserts_d  = num_inserts_q + 32'd1;
          end
        end else if (sweep_pending) begin
          state_d        = S_SWEEP;
          sram_req_d     = 1'b1;
          sram_rd_wr_l_d = 1'b0;
          sram_addr_d    = sweep_addr;
          sram_wr_data_d = '0;
        end
      end
      // Second write reuses the held data word, only the address moves.
      S_WR0: if (sram_ack) begin
        state_d     = S_WR1;
        sram_addr_d = idx1_q;
      end
      S_WR1, S_CLR1, S_SWEEP: if (sram_ack) begin
        state_d    = S_IDLE;
        sram_req_d = 1'b0;
      end
      S_RD0: if (sram_ack) begin
        state_d    = S_RD0_WAIT;
        sram_req_d = 1'b0;
      end
      S_RD0_WAIT: if (sram_rd_vld) begin
        w0_valid_d  = sram_rd_data[VALID_BIT];
        w0_ts_d     = TS_WIDTH'(sram_rd_data[TS_MSB:0]);
        state_d     = S_RD1;
        sram_req_d  = 1'b1;
        sram_addr_d = idx1_q;
      end
      S_RD1: if (sram_ack) begin
        state_d    = S_RD1_WAIT;
        sram_req_d = 1'b0;
      end
      S_RD1_WAIT: if (sram_rd_vld) begin
        state_d = S_EVAL;
        if (hit) begin
          rtt_valid_d   = 1'b1;
          rtt_value_d   = (age0 > age1) ? age0 : age1;
          num_matches_d = num_matches_q + 32'd1;
        end else begin
          num_misses_d  = num_misses_q + 32'd1;
        end
      end
      // rtt_valid_q doubles as the registered hit flag for this cycle.
      S_EVAL: begin
        if (rtt_valid_q) begin
          state_d        = S_CLR0;
          sram_req_d     = 1'b1;
          sram_rd_wr_l_d = 1'b0;
          sram_addr_d    = idx0_q;
          sram_wr_data_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLR0: if (sram_ack) begin
        state_d     = S_CLR1;
        sram_addr_d = idx1_q;
      end
      default: begin
        state_d    = S_IDLE;
        sram_req_d = 1'b0;
      end
    endcase
  end

  wire bloom_rdy_next = (state_d == S_IDLE) && !sweep_pending_next;
  always_comb bloom_rdy_d = bloom_rdy_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      bloom_rdy_q    <= 1'b1;
      sram_req_q     <= 1'b0;
      sram_rd_wr_l_q <= 1'b0;
      sram_addr_q    <= '0;
      sram_wr_data_q <= '0;
      idx0_q         <= '0;
      idx1_q         <= '0;
      ts_q           <= '0;
      ts_req_q       <= '0;
      w0_valid_q     <= 1'b0;
      w0_ts_q        <= '0;
      rtt_valid_q    <= 1'b0;
      rtt_value_q    <= '0;
      num_inserts_q  <= '0;
      num_matches_q  <= '0;
      num_misses_q   <= '0;
    end else begin
      state_q        <= state_d;
      bloom_rdy_q    <= bloom_rdy_d;
      sram_req_q     <= sram_req_d;
      sram_rd_wr_l_q <= sram_rd_wr_l_d;
      sram_addr_q    <= sram_addr_d;
      sram_wr_data_q <= sram_wr_data_d;
      idx0_q         <= idx0_d;
      idx1_q         <= idx1_d;
      ts_q           <= ts_d;
      ts_req_q       <= ts_req_d;
      w0_valid_q     <= w0_valid_d;
      w0_ts_q        <= w0_ts_d;
      rtt_valid_q    <= rtt_valid_d;
      rtt_value_q    <= rtt_value_d;
      num_inserts_q  <= num_inserts_d;
      num_matches_q  <= num_matches_d;
      num_misses_q   <= num_misses_d;
    end
  end

  assign bloom_rdy    = bloom_rdy_q;
  assign sram_req     = sram_req_q;
  assign sram_rd_wr_L = sram_rd_wr_l_q;
  assign sram_addr    = sram_addr_q;
  assign sram_wr_data = sram_wr_data_q;
  assign rtt_valid    = rtt_valid_q;
  assign rtt_value    = rtt_value_q;
  assign num_inserts  = num_inserts_q;
  assign num_matches  = num_matches_q;
  assign num_misses   = num_misses_q;

endmodule
`default_nettype wire
